// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg
//   Shared definitions for the ADC capture buffer: FSM state encoding and
//   default sample/address widths.
package adc_capture_pkg;

    localparam int DW_DEF = 10;   // ADC sample width
    localparam int AW_DEF = 10;   // RAM address width, DEPTH = 2**AW

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_READOUT = 2'd2
    } state_t;

endpackage

// File: rtl/adc_capture_ram.sv
// adc_capture_ram
//   Simple dual-port synchronous RAM, DW x 2**AW, one write port and one
//   read port with registered read data (1-cycle latency). Kept as a
//   separate module so a memory-compiler macro can replace it.
// Ports:
//   i_clk                  clock
//   i_wr_en/i_wr_addr/i_wr_data   write port
//   i_rd_en/i_rd_addr      read request
//   o_rd_data              read data, valid the cycle after i_rd_en
module adc_capture_ram #(
    parameter int DW = 10,
    parameter int AW = 10
) (
    input  logic          i_clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) o_rd_data        <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/adc_capture_buf.sv
// adc_capture_buf
//   Captures cfg_len valid ADC samples into RAM after a cfg_start pulse,
//   then streams them out in order over rd_vld/rd_rdy. RAM reads feed a
//   2-entry skid register so the stream runs at 1 word/cycle and tolerates
//   arbitrary stalls.
// Configuration macro: ADC_CAPTURE_DECIM_EN adds cfg_decim (keep every
//   (cfg_decim+1)-th valid sample). Undefined: every valid sample is kept.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   cfg_start/cfg_abort   arm / abort pulses
//   cfg_len               samples to capture (0 or > DEPTH means DEPTH)
//   adc_vld/adc_data      ADC sample stream
//   rd_vld/rd_data/rd_rdy readout stream
//   busy, done, cap_cnt   status
module adc_capture_buf
    import adc_capture_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef ADC_CAPTURE_DECIM_EN
    input  logic [3:0]    cfg_decim,
`endif
    input  logic          cfg_start,
    input  logic          cfg_abort,
    input  logic [AW:0]   cfg_len,
    input  logic          adc_vld,
    input  logic [DW-1:0] adc_data,
    output logic          rd_vld,
    output logic [DW-1:0] rd_data,
    input  logic          rd_rdy,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   cap_cnt
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    state_t        r_state;
    logic [AW:0]   r_len_q, r_cap_cnt, r_iss_cnt, r_acc_cnt;
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic          r_rd_pend;     // RAM read data lands this cycle
    logic [1:0]    r_sk_cnt;
    logic [DW-1:0] r_sk0, r_sk1;  // r_sk0 is the presented word

    logic [AW:0]   w_len;
    logic          w_dec_ok, w_take, w_cap_last, w_pop, w_last_acc, w_iss;
    logic [1:0]    w_occ;
    logic [DW-1:0] w_ram_q;

    assign w_len      = (cfg_len == '0 || cfg_len > DEPTH) ? DEPTH : cfg_len;
    assign w_take     = (r_state == ST_CAPTURE) && adc_vld && w_dec_ok;
    assign w_cap_last = w_take && (r_cap_cnt == r_len_q - 1'b1);
    assign w_pop      = (r_sk_cnt != 2'd0) && rd_rdy;
    assign w_last_acc = w_pop && (r_acc_cnt == r_len_q - 1'b1);
    // Skid entries plus the read in flight never exceed 2; a pop this cycle
    // frees a slot, which is what lets the stream sustain 1 word/cycle.
    assign w_occ      = r_sk_cnt + {1'b0, r_rd_pend};
    assign w_iss      = (r_state == ST_READOUT) && (r_iss_cnt < r_len_q) &&
                        ((w_occ < 2'd2) || w_pop);

    assign rd_vld  = (r_sk_cnt != 2'd0);
    assign rd_data = r_sk0;
    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_READOUT) && w_last_acc && !cfg_abort;
    assign cap_cnt = r_cap_cnt;

`ifdef ADC_CAPTURE_DECIM_EN
    logic [3:0] r_decim_q, r_dec_cnt;

    assign w_dec_ok = (r_dec_cnt == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_decim_q <= '0;
            r_dec_cnt <= '0;
        end else if (cfg_abort) begin
            r_dec_cnt <= '0;
        end else if (r_state == ST_IDLE && cfg_start) begin
            r_decim_q <= cfg_decim;
            r_dec_cnt <= '0;
        end else if (r_state == ST_CAPTURE && adc_vld) begin
            r_dec_cnt <= (r_dec_cnt == r_decim_q) ? 4'd0 : r_dec_cnt + 4'd1;
        end
    end
`else
    assign w_dec_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_len_q   <= '0;
            r_cap_cnt <= '0;
            r_iss_cnt <= '0;
            r_acc_cnt <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_pend <= 1'b0;
            r_sk_cnt  <= '0;
            r_sk0     <= '0;
            r_sk1     <= '0;
        end else if (cfg_abort) begin
            r_state   <= ST_IDLE;
            r_rd_pend <= 1'b0;
            r_sk_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        r_state   <= ST_CAPTURE;
                        r_len_q   <= w_len;
                        r_wr_ptr  <= '0;
                        r_cap_cnt <= '0;
                        r_rd_ptr  <= '0;
                        r_iss_cnt <= '0;
                        r_acc_cnt <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (w_take) begin
                        r_wr_ptr  <= r_wr_ptr + 1'b1;
                        r_cap_cnt <= r_cap_cnt + 1'b1;
                    end
                    if (w_cap_last) r_state <= ST_READOUT;
                end
                ST_READOUT: begin
                    r_rd_pend <= w_iss;
                    if (w_iss) begin
                        r_rd_ptr  <= r_rd_ptr + 1'b1;
                        r_iss_cnt <= r_iss_cnt + 1'b1;
                    end
                    if (w_pop) r_acc_cnt <= r_acc_cnt + 1'b1;
                    case ({r_rd_pend, w_pop})
                        2'b10: begin
                            if (r_sk_cnt == 2'd0) r_sk0 <= w_ram_q;
                            else                  r_sk1 <= w_ram_q;
                            r_sk_cnt <= r_sk_cnt + 2'd1;
                        end
                        2'b01: begin
                            r_sk0    <= r_sk1;
                            r_sk_cnt <= r_sk_cnt - 2'd1;
                        end
                        2'b11: begin
                            if (r_sk_cnt == 2'd1) begin
                                r_sk0 <= w_ram_q;
                            end else begin
                                r_sk0 <= r_sk1;
                                r_sk1 <= w_ram_q;
                            end
                        end
                        default: ;
                    endcase
                    if (w_last_acc) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    adc_capture_ram #(.DW(DW), .AW(AW)) u_ram (
        .i_clk     (clk),
        .i_wr_en   (w_take),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (adc_data),
        .i_rd_en   (w_iss),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_q)
    );

endmodule

// File: tb/tb_adc_capture_buf.sv
// tb_adc_capture_buf
//   Scoreboard bench for adc_capture_buf (DW=10, AW=4). Captured samples are
//   pushed to exp_q as they are driven; a negedge monitor pops and compares
//   on every rd_vld & rd_rdy handshake and checks hold-stability on stalls.
//   Build with +define+ADC_CAPTURE_DECIM_EN to exercise decimation.
module tb_adc_capture_buf;

    localparam int DW = 10;
    localparam int AW = 4;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          cfg_start = 1'b0, cfg_abort = 1'b0;
    logic [AW:0]   cfg_len = '0;
    logic          adc_vld = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic          rd_rdy = 1'b0;
    logic          rd_vld, busy, done;
    logic [DW-1:0] rd_data;
    logic [AW:0]   cap_cnt;
`ifdef ADC_CAPTURE_DECIM_EN
    logic [3:0]    cfg_decim = '0;
`endif

    int            n_chk = 0, n_fail = 0, n_done = 0, n_acc = 0;
    logic [DW-1:0] exp_q[$];
    bit            rnd_rdy = 1'b0;

    always #5 clk = ~clk;

    adc_capture_buf #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef ADC_CAPTURE_DECIM_EN
        .cfg_decim (cfg_decim),
`endif
        .cfg_start (cfg_start),
        .cfg_abort (cfg_abort),
        .cfg_len   (cfg_len),
        .adc_vld   (adc_vld),
        .adc_data  (adc_data),
        .rd_vld    (rd_vld),
        .rd_data   (rd_data),
        .rd_rdy    (rd_rdy),
        .busy      (busy),
        .done      (done),
        .cap_cnt   (cap_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cap(input int len);
        n_done = 0;
        n_acc  = 0;
        cfg_len   = (AW+1)'(len);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic send(input int d, input bit v, input bit push);
        adc_vld  = v;
        adc_data = DW'(d);
        if (push) exp_q.push_back(DW'(d));
        tick();
        adc_vld = 1'b0;
    endtask

    // Run readout until busy drops, then confirm the stream is fully drained.
    task automatic drain(input string tag);
        int k = 0;
        while (k < 500) begin
            rd_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            k++;
            if (!busy) break;
        end
        rd_rdy = 1'b1;
        if (k >= 500) chk({tag, "_timeout"}, 1, 0);
        chk({tag, "_vld_after"}, rd_vld, 0);
        chk({tag, "_done_cnt"}, n_done, 1);
        chk({tag, "_q_empty"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Handshake monitor / scoreboard.
    bit            prev_hold = 1'b0, prev_abort = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_hold && !prev_abort) begin
                chk("hold_vld", rd_vld, 1);
                chk("hold_data", rd_data, prev_data);
            end
            if (rd_vld && rd_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", rd_data, e);
                end
                n_acc++;
            end
            if (done) begin
                n_done++;
                chk("done_last", exp_q.size(), 0);
            end
            prev_hold  = rd_vld && !rd_rdy;
            prev_data  = rd_data;
            prev_abort = cfg_abort;
        end
    end

    initial begin
        // Reset state
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_vld", rd_vld, 0);
        chk("rst_done", done, 0);
        chk("rst_cap", cap_cnt, 0);
        chk("rst_data", rd_data, 0);
        rst_n  = 1'b1;
        rd_rdy = 1'b1;
        tick();

        // Basic: len 4, data 1..4, first word 2 cycles after READOUT entry
        start_cap(4);
        for (int i = 1; i <= 4; i++) send(i, 1, 1);
        chk("t1_entry_busy", busy, 1);
        chk("t1_entry_vld", rd_vld, 0);
        tick();
        chk("t1_e1_vld", rd_vld, 0);
        tick();
        chk("t1_e2_vld", rd_vld, 1);
        chk("t1_e2_data", rd_data, 1);
        tick(); tick(); tick();
        chk("t1_done", done, 1);
        chk("t1_data4", rd_data, 4);
        tick();
        chk("t1_busy", busy, 0);
        chk("t1_vld", rd_vld, 0);
        chk("t1_done_cnt", n_done, 1);
        chk("t1_cap", cap_cnt, 4);

        // len 0 and len 20 both mean DEPTH = 16
        foreach (cfg_len[b]) ;
        for (int t = 0; t < 2; t++) begin
            start_cap(t == 0 ? 0 : 20);
            for (int i = 0; i < 16; i++) send($urandom_range(0, 1023), 1, 1);
            chk("full_cap_cnt", cap_cnt, 16);
            chk("full_busy", busy, 1);
            send(11, 1, 0);   // READOUT ignores further samples
            send(12, 1, 0);
            drain("full");
            chk("full_cap_hold", cap_cnt, 16);
        end

        // Backpressure: len 8 with random rd_rdy
        rnd_rdy = 1'b1;
        start_cap(8);
        for (int i = 0; i < 8; i++) send(100 + 13 * i, 1, 1);
        drain("bp");
        rnd_rdy = 1'b0;

        // adc_vld gaps
        start_cap(3);
        send(7, 1, 1); send(0, 0, 0); send(0, 0, 0);
        send(9, 1, 1); send(0, 0, 0); send(5, 1, 1);
        chk("gap_cap", cap_cnt, 3);
        drain("gap");

        // Abort in READOUT after 2 of 6 words
        start_cap(6);
        for (int i = 0; i < 6; i++) send(50 + i, 1, 1);
        begin
            int k = 0;
            while (n_acc < 2 && k < 100) begin
                tick();
                k++;
            end
            if (k >= 100) chk("abort_wait_timeout", 1, 0);
        end
        rd_rdy    = 1'b0;
        cfg_abort = 1'b1;
        cfg_start = 1'b1;   // abort wins over start
        cfg_len   = 5'd2;
        tick();
        cfg_abort = 1'b0;
        cfg_start = 1'b0;
        chk("abort_vld", rd_vld, 0);
        chk("abort_busy", busy, 0);
        rd_rdy = 1'b1;
        tick(); tick();
        chk("abort_busy2", busy, 0);
        chk("abort_acc", n_acc, 2);
        chk("abort_no_done", n_done, 0);
        exp_q.delete();

        start_cap(1);
        send(42, 1, 1);
        chk("one_cap", cap_cnt, 1);
        drain("one");

`ifdef ADC_CAPTURE_DECIM_EN
        cfg_decim = 4'd2;
        start_cap(3);
        for (int i = 0; i < 9; i++) send(i, 1, (i % 3) == 0);
        drain("decim");
        chk("decim_cap", cap_cnt, 3);
        cfg_decim = 4'd0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_capture_buf.md
Name: adc_capture_buf

Overview:
- Single-clock capture buffer inside the digital wrapper. It sits directly downstream of the analog clock/ADC interface.
- Armed by `cfg_start`, it records `cfg_len` consecutive valid ADC samples into on-chip RAM.
- It then streams the samples out in order over a valid/ready interface to the pad readout logic.
- Intended for the 200 MHz domain; it performs no CDC of its own.

Parameters:
- DW, 10, ADC sample width in bits.
- AW, 10, RAM address width; DEPTH = 2**AW samples.

Ports:
- clk  in  1  capture/readout clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  single-cycle arm pulse.
- cfg_abort  in  1  single-cycle abort pulse.
- cfg_len  in  AW+1  number of samples to capture.
- adc_vld  in  1  ADC sample strobe.
- adc_data  in  DW  ADC sample.
- rd_vld  out  1  readout word valid.
- rd_data  out  DW  readout word.
- rd_rdy  in  1  readout consumer ready.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the last word is accepted.
- cap_cnt  out  AW+1  samples written in the current capture.

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, and the pointers are 0. Asserting rst_n mid-operation discards all progress; RAM contents are don't-care.
- Length rule: `len_q` is latched on start.
  - `cfg_len` = 0 or `cfg_len` > DEPTH → `len_q` = DEPTH.
  - Otherwise `len_q` = `cfg_len`.
- FSM states: IDLE, CAPTURE, READOUT.
- IDLE:
  - `cfg_start` → CAPTURE next cycle; `wr_ptr` = 0, `cap_cnt` = 0.
  - `adc_vld` is ignored.
- CAPTURE:
  - Each cycle with `adc_vld` = 1 writes `adc_data` to `ram[wr_ptr]` and increments `wr_ptr` and `cap_cnt`.
  - The cycle that writes sample `len_q`-1 moves the FSM to READOUT next cycle. A single valid sample with `len_q` = 1 therefore also transitions.
  - Gaps in `adc_vld` are allowed and are not recorded.
- READOUT:
  - Reads `ram[0..len_q-1]` in order. The RAM has 1-cycle read latency and feeds a 2-entry output skid register.
  - The first `rd_vld` asserts 2 cycles after entry.
  - Sustains 1 word/cycle while `rd_rdy` = 1.
  - `rd_vld`/`rd_data` hold stable until `rd_vld` & `rd_rdy`.
  - Exactly `len_q` words are presented, with no duplicates or drops under arbitrary `rd_rdy` stalls.
  - On acceptance of word `len_q`-1: `done` pulses for 1 cycle and the FSM returns to IDLE in the same edge. `rd_vld` is 0 the next cycle.
- `cfg_start` in CAPTURE or READOUT is ignored.
- `cfg_abort` in any state:
  - Next cycle: IDLE, `rd_vld` = 0, skid flushed, no `done` pulse.
  - `cfg_abort` wins over a simultaneous `cfg_start`, and over a final-word handshake in the same cycle.
- `cap_cnt` holds its final value after capture until the next start.
- Width rules: `wr_ptr` and `rd_ptr` are AW bits. Counters are AW+1 bits so they can reach DEPTH without wrapping. There is no circular wrap; capture stops at `len_q`.

Optional Feature:
- Macro: ADC_CAPTURE_DECIM_EN.
- When defined:
  - Adds input port `cfg_decim` (4 bits), latched on start.
  - Only every (`cfg_decim`+1)-th valid sample is written, starting with the first valid sample after start.
  - A decimation counter resets on start and on abort.
- When undefined:
  - The port is absent and every valid sample is written.
  - Behaviour is identical to `cfg_decim` = 0.

Decomposition:
- Shared package `adc_capture_pkg` holds:
  - FSM state enum: `ST_IDLE` = 2'd0, `ST_CAPTURE` = 2'd1, `ST_READOUT` = 2'd2.
  - Default DW/AW constants.
- One sub-module: `adc_capture_ram`, a simple dual-port sync RAM with 1 write port, 1 read port, registered read data, DW×DEPTH.
  - This is the memory-compiler swap point.
- The FSM, counters and skid register stay in `adc_capture_buf`.

Test Plan:
- Reset-released IDLE: `cfg_start` with `cfg_len` = 4 and `adc_data` = 1,2,3,4 on consecutive `adc_vld`; `rd_rdy` = 1 → `rd_data` 1,2,3,4 on 4 consecutive cycles, starting 2 cycles after READOUT entry. `done` pulses with the 4th word; `busy` drops the next cycle.
- `cfg_len` = 0 with DW=10, AW=4 → exactly 16 samples captured, `cap_cnt` = 16, 16 words read out. `cfg_len` = 20 behaves identically.
- Readout backpressure: `cfg_len` = 8 with random `rd_rdy` (~50%) → 8 words in order, each held stable while `rd_rdy` = 0, `done` exactly once.
- `adc_vld` gaps: `cfg_len` = 3 with `adc_vld` pattern 1,0,0,1,0,1 and data 7,x,x,9,x,5 → readout 7,9,5.
- Abort during READOUT after 2 of 6 words → `rd_vld` = 0 next cycle, no `done`. A new start with `cfg_len` = 1 then works normally.
- With ADC_CAPTURE_DECIM_EN, `cfg_decim` = 2, `cfg_len` = 3, and samples 0..8 back-to-back → readout 0,3,6.
